// File: rtl/ad9648_pkg.sv
// Shared types and helpers for the AD9648 dual-channel capture controller.
package ad9648_pkg;

  localparam int unsigned DEFAULT_DEPTH = 512;
  localparam int unsigned SAMPLE_W      = 14;
  localparam int unsigned WORD_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic [1:0]          pad_a;
    logic [SAMPLE_W-1:0] a;
    logic [1:0]          pad_b;
    logic [SAMPLE_W-1:0] b;
  } sample_word_t;

  // Pack one A/B sample pair into the 32-bit FIFO word layout.
  function automatic logic [WORD_W-1:0] pack_word(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    sample_word_t w;
    w.pad_a = 2'b00;
    w.a     = a;
    w.pad_b = 2'b00;
    w.b     = b;
    return w;
  endfunction

endpackage

// File: rtl/ad9648_sample_fifo.sv
// Show-ahead synchronous FIFO with flush, occupancy count and drop indication.
module ad9648_sample_fifo
  import ad9648_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             empty_q, empty_d;
  logic             full, pop_ok, push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0) && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);
  assign drop_c  = push && !flush && full && !pop_ok;

  // Next pointers/count; head word is pre-fetched so rdata is a flop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    empty_d  = empty_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rdata_d  = '0;
      empty_d  = 1'b1;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      empty_d = (count_d == '0);
      if (count_d == '0) begin
        rdata_d = '0;
      end else if (push_ok && (count_q == CW'(pop_ok))) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = rdata_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/ad9648_capture_ctrl.sv
// AD9648 capture controller: arm/trigger FSM and sample counter feeding a show-ahead FIFO.
module ad9648_capture_ctrl
  import ad9648_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned LEN_W = 10
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             adc_valid,
  input  logic [13:0]      adc_data_a,
  input  logic [13:0]      adc_data_b,
  input  logic             ctrl_arm,
  input  logic [LEN_W-1:0] ctrl_len,
  input  logic             ctrl_trig_mode,
  input  logic [13:0]      ctrl_thresh,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic             rd_empty,
  output logic [LEN_W-1:0] fill_level,
  output logic             status_busy,
  output logic             status_done,
  output logic             status_ovf
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  cap_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [13:0]      thresh_q, thresh_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             flush_c, push_c, drop_c, arm_ok_c, take_c;
  logic [LEN_W-1:0] cnt_inc_c;
  logic [CW-1:0]    fifo_count;

  assign arm_ok_c  = ctrl_arm && (ctrl_len != '0)
                     && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign take_c    = ((state_q == ST_WAIT_TRIG) && adc_valid && (adc_data_a >= thresh_q))
                     || ((state_q == ST_CAPTURE) && adc_valid);
  assign cnt_inc_c = cnt_q + LEN_W'(1);

  // Next-state, counter and push control.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    thresh_d = thresh_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    flush_c  = 1'b0;
    push_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_ok_c) begin
          flush_c  = 1'b1;
          done_d   = 1'b0;
          len_d    = ctrl_len;
          thresh_d = ctrl_thresh;
          cnt_d    = '0;
          state_d  = ctrl_trig_mode ? ST_WAIT_TRIG : ST_CAPTURE;
        end
      end
      ST_WAIT_TRIG, ST_CAPTURE: begin
        if (take_c) begin
          push_c  = 1'b1;
          cnt_d   = cnt_inc_c;
          state_d = ST_CAPTURE;
          if (cnt_inc_c == len_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overflow flag kept apart so it can depend on the FIFO drop strobe.
  always_comb begin
    ovf_d = ovf_q;
    if (flush_c)     ovf_d = 1'b0;
    else if (drop_c) ovf_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      thresh_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      thresh_q <= thresh_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  ad9648_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .flush  (flush_c),
    .push   (push_c),
    .wdata  (pack_word(adc_data_a, adc_data_b)),
    .pop    (rd_en),
    .rdata  (rd_data),
    .empty  (rd_empty),
    .count  (fifo_count),
    .drop_c (drop_c)
  );

  assign fill_level  = LEN_W'(fifo_count);
  assign status_busy = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
  assign status_done = done_q;
  assign status_ovf  = ovf_q;

endmodule

// File: tb/tb_ad9648_capture_ctrl.sv
// Directed bench for ad9648_capture_ctrl with a queue-based reference model checked every cycle.
module tb_ad9648_capture_ctrl;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LEN_W = 10;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic             adc_valid;
  logic [13:0]      adc_data_a, adc_data_b;
  logic             ctrl_arm;
  logic [LEN_W-1:0] ctrl_len;
  logic             ctrl_trig_mode;
  logic [13:0]      ctrl_thresh;
  logic             rd_en;
  logic [31:0]      rd_data;
  logic             rd_empty;
  logic [LEN_W-1:0] fill_level;
  logic             status_busy, status_done, status_ovf;

  ad9648_capture_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .adc_valid      (adc_valid),
    .adc_data_a     (adc_data_a),
    .adc_data_b     (adc_data_b),
    .ctrl_arm       (ctrl_arm),
    .ctrl_len       (ctrl_len),
    .ctrl_trig_mode (ctrl_trig_mode),
    .ctrl_thresh    (ctrl_thresh),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .fill_level     (fill_level),
    .status_busy    (status_busy),
    .status_done    (status_done),
    .status_ovf     (status_ovf)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus capture bookkeeping.
  logic [31:0] mq[$];
  bit m_busy, m_wait, m_done, m_ovf;
  int m_len, m_cnt;
  int unsigned m_thr;

  initial begin
    bit do_pop, do_push;
    forever begin
      @(posedge ACLK or negedge ARESETN);
      if (!ARESETN) begin
        mq.delete();
        m_busy = 0; m_wait = 0; m_done = 0; m_ovf = 0; m_len = 0; m_cnt = 0; m_thr = 0;
      end else begin
        do_pop  = rd_en && (mq.size() > 0);
        do_push = 0;
        if (!m_busy) begin
          if (ctrl_arm && ctrl_len != 0) begin
            mq.delete();
            m_done = 0; m_ovf = 0; m_cnt = 0; m_busy = 1;
            m_len = int'(ctrl_len); m_thr = ctrl_thresh; m_wait = ctrl_trig_mode;
            do_pop = 0;
          end
        end else if (adc_valid && (!m_wait || adc_data_a >= m_thr)) begin
          m_wait = 0;
          m_cnt++;
          if (mq.size() < DEPTH || do_pop) do_push = 1;
          else m_ovf = 1;
          if (m_cnt == m_len) begin
            m_busy = 0;
            m_done = 1;
          end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({2'b00, adc_data_a, 2'b00, adc_data_b});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge ACLK);
      if (check_en) begin
        chk("cyc_rd_empty", 32'(rd_empty), 32'(mq.size() == 0));
        chk("cyc_fill", 32'(fill_level), 32'(mq.size()));
        chk("cyc_rd_data", rd_data, (mq.size() > 0) ? mq[0] : 32'h0);
        chk("cyc_busy", 32'(status_busy), 32'(m_busy));
        chk("cyc_done", 32'(status_done), 32'(m_done));
        chk("cyc_ovf", 32'(status_ovf), 32'(m_ovf));
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: got no finish, want finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic [13:0] a, input logic [13:0] b, input logic rd);
    adc_valid = v; adc_data_a = a; adc_data_b = b; rd_en = rd;
    @(negedge ACLK);
    adc_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic arm(input logic [LEN_W-1:0] len, input logic mode, input logic [13:0] thr);
    ctrl_arm = 1'b1; ctrl_len = len; ctrl_trig_mode = mode; ctrl_thresh = thr;
    @(negedge ACLK);
    ctrl_arm = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0;
    adc_valid = 0; adc_data_a = 0; adc_data_b = 0; rd_en = 0;
    ctrl_arm = 0; ctrl_len = 0; ctrl_trig_mode = 0; ctrl_thresh = 0;
    repeat (2) @(negedge ACLK);
    chk("rst_empty", 32'(rd_empty), 32'd1);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_data", rd_data, 32'h0);
    chk("rst_busy", 32'(status_busy), 32'd0);
    chk("rst_done", 32'(status_done), 32'd0);
    chk("rst_ovf", 32'(status_ovf), 32'd0);
    ARESETN = 1'b1;
    check_en = 1'b1;

    // len = 0 arm and valid while idle are both ignored
    arm(10'd0, 1'b0, 14'd0);
    chk("len0_busy", 32'(status_busy), 32'd0);
    drive(1'b1, 14'd5, 14'd5, 1'b0);
    chk("idle_valid_fill", 32'(fill_level), 32'd0);

    // immediate capture of four pairs
    arm(10'd4, 1'b0, 14'd0);
    chk("imm_busy", 32'(status_busy), 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b1, 14'(i + 1), 14'(16'h3FFF - i), 1'b0);
    chk("imm_done", 32'(status_done), 32'd1);
    chk("imm_fill", 32'(fill_level), 32'd4);
    chk("imm_head", rd_data, 32'h00013FFF);
    drive(1'b1, 14'h1111, 14'h2222, 1'b0);
    chk("done_valid_fill", 32'(fill_level), 32'd4);
    drive(1'b0, 14'd0, 14'd0, 1'b1);
    chk("imm_second", rd_data, 32'h00023FFE);
    repeat (4) drive(1'b0, 14'd0, 14'd0, 1'b1);
    chk("underflow_fill", 32'(fill_level), 32'd0);

    // threshold trigger
    arm(10'd2, 1'b1, 14'h2000);
    drive(1'b1, 14'h1FFE, 14'h0123, 1'b0);
    drive(1'b1, 14'h1FFF, 14'h0123, 1'b0);
    chk("thr_fill_pre", 32'(fill_level), 32'd0);
    chk("thr_busy_pre", 32'(status_busy), 32'd1);
    drive(1'b1, 14'h2000, 14'h0123, 1'b0);
    chk("thr_head", rd_data, 32'h20000123);
    chk("thr_busy3", 32'(status_busy), 32'd1);
    drive(1'b1, 14'h2001, 14'h0123, 1'b0);
    chk("thr_busy4", 32'(status_busy), 32'd0);
    chk("thr_fill", 32'(fill_level), 32'd2);
    repeat (2) drive(1'b0, 14'd0, 14'd0, 1'b1);

    // re-arm while capturing is ignored
    arm(10'd8, 1'b0, 14'd0);
    repeat (2) drive(1'b1, 14'h0100, 14'h0200, 1'b0);
    arm(10'd3, 1'b1, 14'h3FFF);
    chk("rearm_fill", 32'(fill_level), 32'd2);
    for (int i = 0; i < 5; i++) drive(1'b1, 14'(i), 14'(i), 1'b0);
    chk("rearm_done7", 32'(status_done), 32'd0);
    drive(1'b1, 14'h0033, 14'h0044, 1'b0);
    chk("rearm_done8", 32'(status_done), 32'd1);
    chk("rearm_fill8", 32'(fill_level), 32'd8);
    repeat (8) drive(1'b0, 14'd0, 14'd0, 1'b1);

    // overflow: DEPTH+3 samples without reads
    arm(10'(DEPTH + 3), 1'b0, 14'd0);
    for (int i = 0; i < DEPTH + 3; i++) drive(1'b1, 14'(i), 14'(i * 3), 1'b0);
    chk("ovf_fill", 32'(fill_level), 32'(DEPTH));
    chk("ovf_flag", 32'(status_ovf), 32'd1);
    chk("ovf_done", 32'(status_done), 32'd1);
    chk("ovf_head", rd_data, 32'h0);

    // full FIFO with simultaneous push and pop
    arm(10'(DEPTH + 2), 1'b0, 14'd0);
    chk("arm_clr_ovf", 32'(status_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 14'(i + 100), 14'(i), 1'b0);
    chk("full_fill", 32'(fill_level), 32'(DEPTH));
    repeat (2) drive(1'b1, 14'h3ABC, 14'h1234, 1'b1);
    chk("pp_fill", 32'(fill_level), 32'(DEPTH));
    chk("pp_ovf", 32'(status_ovf), 32'd0);
    chk("pp_done", 32'(status_done), 32'd1);
    chk("pp_head", rd_data, 32'h00660002);
    repeat (DEPTH + 1) drive(1'b0, 14'd0, 14'd0, 1'b1);

    // asynchronous reset mid-capture, then clean re-arm
    arm(10'd8, 1'b0, 14'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 14'(i + 7), 14'(i), 1'b0);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_empty", 32'(rd_empty), 32'd1);
    chk("arst_busy", 32'(status_busy), 32'd0);
    chk("arst_fill", 32'(fill_level), 32'd0);
    chk("arst_data", rd_data, 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    arm(10'd2, 1'b0, 14'd0);
    drive(1'b1, 14'h0AAA, 14'h0555, 1'b0);
    drive(1'b1, 14'h0BBB, 14'h0666, 1'b0);
    chk("post_head", rd_data, 32'h0AAA0555);
    chk("post_fill", 32'(fill_level), 32'd2);
    chk("post_done", 32'(status_done), 32'd1);
    drive(1'b0, 14'd0, 14'd0, 1'b1);
    chk("post_next", rd_data, 32'h0BBB0666);

    @(negedge ACLK);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
